// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
//   port_state_e : per-port request lifecycle (IDLE -> BUSY -> HOLD -> IDLE)
//   NUM_PORTS    : number of requesters (0 = instruction fetch, 1 = load/store)
//   port_idx_t   : index of one requester
package sram_port_arbiter_pkg;

  localparam int NUM_PORTS = 2;

  typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // may accept a new request
    BUSY = 2'd1,  // SRAM read data arrives this cycle
    HOLD = 2'd2   // response buffered, waiting for resp_ready
  } port_state_e;

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin picker.
//   eligible   in  [1:0] ports that may be granted this cycle
//   last_grant in  1     port granted most recently
//   gnt_onehot out [1:0] at most one bit set; the port that wins this cycle
// On a tie the port that did not win last time is chosen; a lone eligible
// port always wins.
module sram_rr_pick
  import sram_port_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] eligible,
  input  port_idx_t            last_grant,
  output logic [NUM_PORTS-1:0] gnt_onehot
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    gnt_onehot = '0;
    if (&eligible) begin
      gnt_onehot[~last_grant] = 1'b1;
    end else begin
      gnt_onehot = eligible;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port, byte-write SRAM (1-cycle read latency) between the
// instruction-fetch port (0) and the load/store port (1).
//   clock, reset_n            single clock; synchronous active-low reset
//   req_valid/ready[p]        request handshake; ready only in the accept cycle
//   req_we/addr/wdata[p]      byte strobes (0 = read), word address, write data
//   resp_valid/ready[p]       response buffer full / consumed by requester
//   resp_rdata[p]             word at the address before any write (read-old)
//   sram_en/we/addr/wdata     macro controls, driven combinationally on a grant
//   sram_rdata                macro read data, valid the cycle after sram_en
// Each port has one access in flight at most: accept -> BUSY (SRAM returns
// data) -> HOLD (buffered until consumed) -> IDLE.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [NUM_PORTS-1:0]                  req_valid,
  output logic [NUM_PORTS-1:0]                  req_ready,
  input  logic [NUM_PORTS-1:0][NUM_COL-1:0]     req_we,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]                  resp_valid,
  input  logic [NUM_PORTS-1:0]                  resp_ready,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  resp_rdata,
  output logic                                  sram_en,
  output logic [NUM_COL-1:0]                    sram_we,
  output logic [ADDR_WIDTH-1:0]                 sram_addr,
  output logic [DATA_WIDTH-1:0]                 sram_wdata,
  input  logic [DATA_WIDTH-1:0]                 sram_rdata
);

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] gnt_onehot;
  port_idx_t            gnt_idx;
  port_idx_t            last_grant_q;

  sram_rr_pick u_pick (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .gnt_onehot (gnt_onehot)
  );

  assign req_ready = gnt_onehot;
  assign gnt_idx   = port_idx_t'(gnt_onehot[1]);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    port_state_e           state_q;
    port_state_e           state_d;
    logic [DATA_WIDTH-1:0] resp_buf_q;

    // Gated by reset_n so nothing is accepted, and the SRAM stays idle,
    // while reset is being held.
    assign eligible[p] = reset_n & req_valid[p] & (state_q == IDLE);

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE:    if (gnt_onehot[p]) state_d = BUSY;
        BUSY:    state_d = HOLD;
        HOLD:    if (resp_ready[p]) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its inputs as they were before the clock edge.
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
    end

    // Only the port in BUSY owns the current SRAM read data, so two
    // back-to-back grants each land in their own buffer.
    always_ff @(posedge clock) begin
      // NOTE: the buffer is reset because it is visible on resp_rdata.
      if (!reset_n)               resp_buf_q <= '0;
      else if (state_q == BUSY)   resp_buf_q <= sram_rdata;
    end

    assign resp_valid[p] = (state_q == HOLD);
    assign resp_rdata[p] = resp_buf_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)          last_grant_q <= port_idx_t'(1);
    else if (|gnt_onehot)  last_grant_q <= gnt_idx;
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (|gnt_onehot) begin
      sram_en    = 1'b1;
      sram_we    = req_we[gnt_idx];
      sram_addr  = req_addr[gnt_idx];
      sram_wdata = req_wdata[gnt_idx];
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed sequences, a vector
// table for the handshake/turnaround pattern, and a randomized run checked
// against a transaction-level model.
module tb_sram_port_arbiter;

  localparam int NUM_COL    = 4;
  localparam int COL_WIDTH  = 8;
  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic                                clock = 1'b0;
  logic                                reset_n;
  logic [1:0]                          req_valid;
  logic [1:0]                          req_ready;
  logic [1:0][NUM_COL-1:0]             req_we;
  logic [1:0][ADDR_WIDTH-1:0]          req_addr;
  logic [1:0][DATA_WIDTH-1:0]          req_wdata;
  logic [1:0]                          resp_valid;
  logic [1:0]                          resp_ready;
  logic [1:0][DATA_WIDTH-1:0]          resp_rdata;
  logic                                sram_en;
  logic [NUM_COL-1:0]                  sram_we;
  logic [ADDR_WIDTH-1:0]               sram_addr;
  logic [DATA_WIDTH-1:0]               sram_wdata;
  logic [DATA_WIDTH-1:0]               sram_rdata;

  always #5 clock = ~clock;

  sram_port_arbiter #(
    .NUM_COL    (NUM_COL),
    .COL_WIDTH  (COL_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Behavioural SRAM macro: read-old, byte enables, 1-cycle read latency.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (sram_en) begin
      sram_rdata <= mem[sram_addr];
      for (int b = 0; b < NUM_COL; b++)
        if (sram_we[b]) mem[sram_addr][b*COL_WIDTH +: COL_WIDTH] = sram_wdata[b*COL_WIDTH +: COL_WIDTH];
    end
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked 3
  // units later, well before the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = '0;
  endtask

  task automatic do_reset();
    cyc();
    reset_n = 1'b0;
    idle_inputs();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    idle_inputs();
    resp_ready = 2'b11;
    for (int i = 0; i < 4; i++) cyc();
    idle_inputs();
  endtask

  typedef struct {
    logic [1:0] rv;      // req_valid
    logic [1:0] rr;      // resp_ready
    logic [1:0] ready;   // expected req_ready
    logic [1:0] rvalid;  // expected resp_valid
  } vec_t;
  vec_t tbl [11];

  // Transaction-level reference for the randomized run.
  logic [DATA_WIDTH-1:0] ref_mem [DEPTH];
  bit                    pend [2];
  bit                    held [2];
  logic [DATA_WIDTH-1:0] exp_data [2];
  int                    last_win;
  int                    win;
  bit                    el0, el1;
  logic [1:0]            exp_ready;
  int                    busy_cycles;
  int                    p1_grants;
  logic [DATA_WIDTH-1:0] exp_word;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[10'h005] = 32'hDEADBEEF;
    mem[10'h3FF] = 32'h11223344;
    mem[10'h010] = 32'hA0A0_0010;
    mem[10'h020] = 32'hB0B0_0020;
    mem[10'h030] = 32'h3030_3030;
    mem[10'h040] = 32'h4040_4040;
    mem[10'h050] = 32'h5050_5050;
    mem[10'h060] = 32'h6060_6060;

    // 1: reset held with both requests valid
    reset_n = 1'b0;
    idle_inputs();
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cyc();
      settle();
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_resp_valid", resp_valid, 2'b00);
      check("rst_sram_en", sram_en, 1'b0);
    end
    check("rst_resp_rdata", resp_rdata, 64'h0);
    cyc();
    reset_n = 1'b1;
    idle_inputs();

    // 2: single read on port 0, turnaround of 3 cycles
    cyc();
    req_valid = 2'b01; req_addr[0] = 10'h005; resp_ready = 2'b01;
    settle();
    check("rd_accept_ready", req_ready, 2'b01);
    check("rd_accept_en", sram_en, 1'b1);
    check("rd_accept_addr", sram_addr, 10'h005);
    check("rd_accept_we", sram_we, 4'b0000);
    cyc(); settle();
    check("rd_busy_ready", req_ready, 2'b00);
    check("rd_busy_rvalid", resp_valid, 2'b00);
    cyc(); settle();
    check("rd_hold_rvalid", resp_valid, 2'b01);
    check("rd_hold_rdata", resp_rdata[0], 32'hDEADBEEF);
    check("rd_hold_ready", req_ready, 2'b00);
    cyc(); settle();
    check("rd_reaccept_ready", req_ready, 2'b01);
    drain();

    // 3: byte write on port 1 returns the old word, then read back merged word
    cyc();
    req_valid = 2'b10; req_we[1] = 4'b0010; req_addr[1] = 10'h3FF;
    req_wdata[1] = 32'h0000AB00; resp_ready = 2'b10;
    settle();
    check("wr_ready", req_ready, 2'b10);
    check("wr_sram_we", sram_we, 4'b0010);
    check("wr_sram_wdata", sram_wdata, 32'h0000AB00);
    cyc(); req_valid = 2'b00; req_we = '0; settle();
    cyc(); settle();
    check("wr_resp_valid", resp_valid, 2'b10);
    check("wr_resp_old", resp_rdata[1], 32'h11223344);
    cyc(); req_valid = 2'b10; settle();
    check("wr_rd_ready", req_ready, 2'b10);
    cyc(); req_valid = 2'b00; settle();
    cyc(); settle();
    check("wr_rd_merged", resp_rdata[1], 32'h1122AB44);
    drain();

    // Vector table: handshake, HOLD blocking and backpressure pattern
    tbl[0]  = '{2'b11, 2'b11, 2'b01, 2'b00};
    tbl[1]  = '{2'b11, 2'b11, 2'b10, 2'b00};
    tbl[2]  = '{2'b11, 2'b11, 2'b00, 2'b01};
    tbl[3]  = '{2'b11, 2'b11, 2'b01, 2'b10};
    tbl[4]  = '{2'b11, 2'b11, 2'b10, 2'b00};
    tbl[5]  = '{2'b00, 2'b00, 2'b00, 2'b01};
    tbl[6]  = '{2'b11, 2'b00, 2'b00, 2'b11};
    tbl[7]  = '{2'b00, 2'b10, 2'b00, 2'b11};
    tbl[8]  = '{2'b11, 2'b00, 2'b10, 2'b01};
    tbl[9]  = '{2'b01, 2'b01, 2'b00, 2'b01};
    tbl[10] = '{2'b01, 2'b00, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cyc();
      idle_inputs();
      req_addr[0] = 10'h010; req_addr[1] = 10'h020;
      req_valid = tbl[i].rv; resp_ready = tbl[i].rr;
      settle();
      check($sformatf("tbl%0d_ready", i), req_ready, tbl[i].ready);
      check($sformatf("tbl%0d_rvalid", i), resp_valid, tbl[i].rvalid);
      check($sformatf("tbl%0d_en", i), sram_en, |tbl[i].ready);
      if (tbl[i].rvalid[0]) check($sformatf("tbl%0d_rdata0", i), resp_rdata[0], 32'hA0A0_0010);
      if (tbl[i].rvalid[1]) check($sformatf("tbl%0d_rdata1", i), resp_rdata[1], 32'hB0B0_0020);
    end
    drain();

    // 4: contention, both ports always requesting
    do_reset();
    busy_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      req_valid = 2'b11; resp_ready = 2'b11;
      req_addr[0] = 10'h030; req_addr[1] = 10'h040;
      settle();
      exp_ready = (i % 3 == 0) ? 2'b01 : (i % 3 == 1) ? 2'b10 : 2'b00;
      check($sformatf("cont%0d_grant", i), req_ready, exp_ready);
      if (sram_en) busy_cycles++;
      if (resp_valid[0]) check("cont_rdata0", resp_rdata[0], 32'h3030_3030);
      if (resp_valid[1]) check("cont_rdata1", resp_rdata[1], 32'h4040_4040);
    end
    check("cont_busy_ge8", 64'(busy_cycles >= 8), 64'd1);
    drain();

    // 5: backpressure on port 0 while port 1 keeps cycling
    do_reset();
    p1_grants = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      req_valid = 2'b11; resp_ready = 2'b10;
      req_addr[0] = 10'h050; req_addr[1] = 10'h060;
      settle();
      if (i >= 1) check("bp_p0_not_granted", req_ready[0], 1'b0);
      if (i >= 2) begin
        check("bp_p0_valid", resp_valid[0], 1'b1);
        check("bp_p0_stable", resp_rdata[0], 32'h5050_5050);
      end
      if (i >= 1 && i <= 9 && req_ready[1]) p1_grants++;
      if (resp_valid[1]) check("bp_p1_rdata", resp_rdata[1], 32'h6060_6060);
    end
    check("bp_p1_every3", p1_grants, 3);
    drain();

    // 6: reset while port 0 is in BUSY after winning the last grant
    do_reset();
    cyc();
    req_valid = 2'b01; req_addr[0] = 10'h070; resp_ready = 2'b11;
    settle();
    check("rmid_accept", req_ready, 2'b01);
    cyc();
    reset_n = 1'b0; req_valid = 2'b00;
    settle();
    check("rmid_rst_en", sram_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      reset_n = 1'b1;
      settle();
      check("rmid_no_resp", resp_valid, 2'b00);
    end
    cyc();
    req_valid = 2'b11;
    settle();
    check("rmid_tie_port0", req_ready, 2'b01);
    drain();

    // Randomized run against the transaction-level model
    do_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
    pend[0] = 0; pend[1] = 0; held[0] = 0; held[1] = 0;
    last_win = 1;
    for (int c = 0; c < 400; c++) begin
      cyc();
      req_valid  = 2'($urandom_range(3, 0));
      resp_ready = 2'($urandom_range(3, 0));
      for (int p = 0; p < 2; p++) begin
        req_addr[p]  = 10'h100 + 10'($urandom_range(7, 0));
        req_we[p]    = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 1)) : 4'b0000;
        req_wdata[p] = $urandom();
      end
      settle();

      el0 = req_valid[0] && !pend[0] && !held[0];
      el1 = req_valid[1] && !pend[1] && !held[1];
      if (el0 && el1) win = 1 - last_win;
      else if (el0)   win = 0;
      else if (el1)   win = 1;
      else            win = -1;
      exp_ready = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;

      check("rnd_ready", req_ready, exp_ready);
      check("rnd_en", sram_en, win >= 0);
      check("rnd_addr", sram_addr, (win >= 0) ? req_addr[win] : 10'h0);
      check("rnd_we", sram_we, (win >= 0) ? req_we[win] : 4'h0);
      check("rnd_wdata", sram_wdata, (win >= 0) ? req_wdata[win] : 32'h0);
      check("rnd_rvalid", resp_valid, {held[1], held[0]});
      for (int p = 0; p < 2; p++)
        if (held[p]) check($sformatf("rnd_rdata%0d", p), resp_rdata[p], exp_data[p]);

      // Advance the model across the coming clock edge.
      for (int p = 0; p < 2; p++) begin
        if (held[p] && resp_ready[p]) held[p] = 0;
        if (pend[p]) begin
          pend[p] = 0;
          held[p] = 1;
        end
      end
      if (win >= 0) begin
        pend[win]     = 1;
        exp_data[win] = ref_mem[req_addr[win]];
        exp_word      = ref_mem[req_addr[win]];
        for (int b = 0; b < NUM_COL; b++)
          if (req_we[win][b]) exp_word[b*COL_WIDTH +: COL_WIDTH] = req_wdata[win][b*COL_WIDTH +: COL_WIDTH];
        ref_mem[req_addr[win]] = exp_word;
        last_win = win;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
